// File: rtl/pipe_hazard_if.sv
// Pipeline-control bus between the core datapath and the hazard sequencer.
interface pipe_hazard_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        mem_access;
  logic        mem_ack;
  logic        mem_req;
  logic        pc_le;
  logic        ifid_le;
  logic        idex_le;
  logic        exmem_le;
  logic        memwb_le;
  logic        ifid_flush;
  logic        idex_flush;
  logic        mem_err;
  logic [15:0] stall_cnt;

  // Datapath side: presents hazard inputs, consumes controls.
  modport master (
    output id_rs, id_rt, ex_memread, ex_rt, branch_taken, mem_access, mem_ack,
    input  mem_req, pc_le, ifid_le, idex_le, exmem_le, memwb_le,
           ifid_flush, idex_flush, mem_err, stall_cnt
  );

  // Sequencer side.
  modport slave (
    input  id_rs, id_rt, ex_memread, ex_rt, branch_taken, mem_access, mem_ack,
    output mem_req, pc_le, ifid_le, idex_le, exmem_le, memwb_le,
           ifid_flush, idex_flush, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: load-use stalls, branch flushes,
// multi-cycle data-memory waits with timeout, and a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  pipe_hazard_if.slave bus
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic load_use_c;
  logic mem_stall_c;
  logic mem_req_c;
  logic mem_err_c;
  logic pc_le_c, ifid_le_c, idex_le_c, exmem_le_c, memwb_le_c;
  logic ifid_flush_c, idex_flush_c;

  // Load in EX writes a register the instruction in ID reads ($0 never hazards).
  always_comb begin
    load_use_c = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                 ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
  end

  // State, wait counter and stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state, pipeline controls and counter update.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    mem_stall_c  = 1'b0;
    mem_req_c    = 1'b0;
    mem_err_c    = 1'b0;
    pc_le_c      = 1'b0;
    ifid_le_c    = 1'b0;
    idex_le_c    = 1'b0;
    exmem_le_c   = 1'b0;
    memwb_le_c   = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;

    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          mem_req_c   = bus.mem_access;
          mem_stall_c = bus.mem_access && !bus.mem_ack;
          if (bus.mem_access && !bus.mem_ack) begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          mem_req_c   = 1'b1;
          mem_stall_c = !bus.mem_ack;
          if (bus.mem_ack) begin
            // An ack in the would-be timeout cycle still completes the access.
            state_d    = ST_RUN;
            wait_cnt_d = '0;
          end else if ((9'({1'b0, wait_cnt_q}) + 9'd1) == 9'(MEM_TIMEOUT)) begin
            state_d = ST_ERROR;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
        ST_ERROR: begin
          mem_err_c = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase

      if (state_q != ST_ERROR) begin
        if (mem_stall_c) begin
          // Whole pipe frozen; EX holds, so a pending branch is acted on at completion.
          pc_le_c = 1'b0;
        end else if (bus.branch_taken) begin
          pc_le_c      = 1'b1;
          ifid_le_c    = 1'b1;
          idex_le_c    = 1'b1;
          exmem_le_c   = 1'b1;
          memwb_le_c   = 1'b1;
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (load_use_c) begin
          idex_le_c    = 1'b1;
          exmem_le_c   = 1'b1;
          memwb_le_c   = 1'b1;
          idex_flush_c = 1'b1;
        end else begin
          pc_le_c    = 1'b1;
          ifid_le_c  = 1'b1;
          idex_le_c  = 1'b1;
          exmem_le_c = 1'b1;
          memwb_le_c = 1'b1;
        end

        if (!pc_le_c && (stall_cnt_q != CNT_MAX)) begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.mem_req    = mem_req_c;
  assign bus.mem_err    = mem_err_c;
  assign bus.pc_le      = pc_le_c;
  assign bus.ifid_le    = ifid_le_c;
  assign bus.idex_le    = idex_le_c;
  assign bus.exmem_le   = exmem_le_c;
  assign bus.memwb_le   = memwb_le_c;
  assign bus.ifid_flush = ifid_flush_c;
  assign bus.idex_flush = idex_flush_c;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage MIPS core. It drives the load-enable and flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions: load-use hazards, taken-branch flushes, and multi-cycle data-memory accesses, which use a req/ack handshake with a timeout. It also keeps a saturating stall-cycle performance counter.

## Interface

Parameters:
- MEM_TIMEOUT, default 15: number of consecutive unacknowledged request cycles that trips the error state. Legal range is 2..255.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- ex_memread  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of the load in EX
- branch_taken  in  1  branch resolved taken in EX
- mem_access  in  1  instruction in MEM is a load or store
- mem_ack  in  1  data memory completes the current access this cycle
- mem_req  out  1  data memory request
- pc_le, ifid_le, idex_le, exmem_le, memwb_le  out  1 each  register load enables
- ifid_flush, idex_flush  out  1 each  load a bubble (synchronous clear) into IF/ID or ID/EX
- mem_err  out  1  memory timeout; sticky until reset
- stall_cnt  out  16  number of cycles with pc_le=0, saturating

## Operation

- FSM states: RUN, MEM_WAIT, ERROR. State register, wait_cnt[7:0] and stall_cnt are registered; all other outputs are combinational from state and inputs.
- Control signals, evaluated in priority order:
  - **Memory stall.** Condition: (RUN and mem_access and !mem_ack) or (MEM_WAIT and !mem_ack). Effect: all five le=0, both flushes=0. MEM/WB holds its value, and the repeated writeback is idempotent.
  - **Branch flush.** Condition: branch_taken. Effect: all le=1, ifid_flush=1, idex_flush=1. Branch wins over a simultaneous load-use hazard.
  - **Load-use stall.** Condition: ex_memread and ex_rt!=0 and (ex_rt==id_rs or ex_rt==id_rt). Effect: pc_le=0, ifid_le=0, idex_flush=1, all other le=1.
  - **Default.** All le=1, both flushes=0.
- mem_req=1 in RUN when mem_access=1, and always in MEM_WAIT. Otherwise 0.
- While a memory stall is active, flushes are deferred. EX is frozen, so branch_taken stays stable and is acted on in the completion cycle.
- Ack cycle: in MEM_WAIT with mem_ack=1, the memory stall is not active. Outputs follow the lower-priority rules, mem_req=1, and the next state is RUN.
- RUN transitions:
  - mem_access and !mem_ack → MEM_WAIT, wait_cnt←1.
  - mem_access and mem_ack → single-cycle access, no stall, stay in RUN.
- MEM_WAIT transitions:
  - mem_ack → RUN.
  - !mem_ack and wait_cnt+1==MEM_TIMEOUT → ERROR.
  - !mem_ack otherwise → wait_cnt←wait_cnt+1.
- ERROR outputs: all le=0, flushes=0, mem_req=0, mem_err=1. ERROR exits only on reset.
- stall_cnt increments by 1 on each cycle with pc_le=0 in RUN or MEM_WAIT. It holds at 16'hFFFF and does not increment in ERROR.

## Timing

- Reset: sampled on the clock edge. While reset=1, outputs are forced to: all le=0, flushes=0, mem_req=0, mem_err=0. After the edge: state=RUN, wait_cnt=0, stall_cnt=0.
- Reset asserted mid-access or in ERROR aborts the access. The next cycle is RUN, with mem_req following mem_access.
- Controls take effect combinationally in the same cycle, so registers update at the next edge.
- Load-use stall costs exactly 1 cycle. In the following cycle the load has moved to MEM, ex_memread=0 for the bubble, and the hazard clears.
- A memory access acked after N cycles (N≥1 including the request cycle) stalls the pipeline for N-1 cycles.
- Timeout: ERROR is entered at the edge ending the MEM_TIMEOUT-th consecutive cycle with mem_req=1 and mem_ack=0.
- An ack arriving in the cycle that would otherwise trip the timeout wins: the next state is RUN.

## Test plan

- **Load-use hazard.** ex_memread=1, ex_rt=8, id_rs=8, mem_access=0 for 1 cycle. Expect pc_le=0, ifid_le=0, idex_flush=1, idex_le=exmem_le=memwb_le=1, stall_cnt 0→1. Repeat with ex_rt=0: no stall.
- **Branch vs hazard.** branch_taken=1 together with the load-use condition above. Expect all le=1, ifid_flush=idex_flush=1, stall_cnt unchanged.
- **Memory wait.** mem_access=1, mem_ack=0 for cycles 0-2, mem_ack=1 in cycle 3. Expect le=0 in cycles 0-2, mem_req=1 in cycles 0-3, le=1 in cycle 3, RUN from cycle 4, stall_cnt=3. With mem_ack=1 in cycle 0: no stall.
- **Deferred flush.** branch_taken=1 held during the wait above. Expect flushes=0 in cycles 0-2 and ifid_flush=idex_flush=1 in cycle 3.
- **Timeout.** MEM_TIMEOUT=4, mem_access=1, mem_ack never asserted. Expect mem_err=1 and mem_req=0 from cycle 4 onward, ERROR held across 20 cycles, stall_cnt=4. Then assert reset for 1 cycle: mem_err=0, stall_cnt=0, and with mem_access=0 all le=1.
- **Saturation.** Hold a memory stall for 70000 cycles with MEM_TIMEOUT=255 and ack every 200 cycles. Expect stall_cnt to stop at 65535.
